// File: rtl/wb_regfile.sv
// Write-back select and 32-entry architectural register file with two async read ports.
// Optional internal write-before-read bypass is compiled in with `define REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  RegWrite_in,
    input  logic                  MemtoReg_in,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] ALU_result_in,
    input  logic [ADDR_WIDTH-1:0] Dest_Reg_Addr_in,
    input  logic [ADDR_WIDTH-1:0] Read_Addr_1,
    input  logic [ADDR_WIDTH-1:0] Read_Addr_2,
    output logic [DATA_WIDTH-1:0] Read_Data_1,
    output logic [DATA_WIDTH-1:0] Read_Data_2,
    output logic [DATA_WIDTH-1:0] WB_Data_out,
    output logic                  WB_Valid_out
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] wr_data_d;
    logic                  wr_en_d;

    assign wr_data_d    = MemtoReg_in ? mem_data_in : ALU_result_in;
    assign wr_en_d      = (RegWrite_in == 1'b1) && (Dest_Reg_Addr_in != '0);
    assign WB_Data_out  = wr_data_d;
    assign WB_Valid_out = wr_en_d;

    // Entry 0 is cleared by reset and never written, so it stays zero in storage too.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            regs_q[Dest_Reg_Addr_in] <= wr_data_d;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] data;
        data = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
        if (!reset && wr_en_d && (addr == Dest_Reg_Addr_in)) begin
            data = wr_data_d;
        end
`endif
        if (addr == '0) begin
            data = '0;
        end
        return data;
    endfunction

    always_comb begin
        Read_Data_1 = read_port(Read_Addr_1);
        Read_Data_2 = read_port(Read_Addr_2);
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed literal checks plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_wb_regfile;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        RegWrite_in = 1'b0;
    logic        MemtoReg_in = 1'b0;
    logic [31:0] mem_data_in = '0;
    logic [31:0] ALU_result_in = '0;
    logic [4:0]  Dest_Reg_Addr_in = '0;
    logic [4:0]  Read_Addr_1 = '0;
    logic [4:0]  Read_Addr_2 = '0;
    logic [31:0] Read_Data_1;
    logic [31:0] Read_Data_2;
    logic [31:0] WB_Data_out;
    logic        WB_Valid_out;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;
    logic [31:0] model [32];

    wb_regfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock(clock),
        .reset(reset),
        .RegWrite_in(RegWrite_in),
        .MemtoReg_in(MemtoReg_in),
        .mem_data_in(mem_data_in),
        .ALU_result_in(ALU_result_in),
        .Dest_Reg_Addr_in(Dest_Reg_Addr_in),
        .Read_Addr_1(Read_Addr_1),
        .Read_Addr_2(Read_Addr_2),
        .Read_Data_1(Read_Data_1),
        .Read_Data_2(Read_Data_2),
        .WB_Data_out(WB_Data_out),
        .WB_Valid_out(WB_Valid_out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the architectural register contents, updated on each edge.
    initial begin
        for (int i = 0; i < 32; i++) model[i] = '0;
    end

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] <= '0;
        end else if (RegWrite_in && Dest_Reg_Addr_in != 5'd0) begin
            model[Dest_Reg_Addr_in] <= MemtoReg_in ? mem_data_in : ALU_result_in;
        end
    end

    function automatic logic [31:0] exp_read(input logic [4:0] addr);
        logic [31:0] v;
        v = model[addr];
`ifdef REGFILE_BYPASS_EN
        if (!reset && RegWrite_in && Dest_Reg_Addr_in != 5'd0 && addr == Dest_Reg_Addr_in)
            v = MemtoReg_in ? mem_data_in : ALU_result_in;
`endif
        if (addr == 5'd0) v = '0;
        return v;
    endfunction

    // Compare process: outputs are checked mid-cycle against the model.
    always @(negedge clock) begin
        if (check_en) begin
            chk("wb_data", WB_Data_out, MemtoReg_in ? mem_data_in : ALU_result_in);
            chk("wb_valid", {31'd0, WB_Valid_out},
                {31'd0, RegWrite_in && (Dest_Reg_Addr_in != 5'd0)});
            chk("rd1_model", Read_Data_1, exp_read(Read_Addr_1));
            chk("rd2_model", Read_Data_2, exp_read(Read_Addr_2));
        end
    end

    // One cycle: inputs change just after the rising edge; returns at the falling edge.
    task automatic cyc(input logic rst, input logic rw, input logic m2r,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] dest, input logic [4:0] ra1, input logic [4:0] ra2);
        @(posedge clock);
        #1;
        reset = rst;
        RegWrite_in = rw;
        MemtoReg_in = m2r;
        mem_data_in = mem;
        ALU_result_in = alu;
        Dest_Reg_Addr_in = dest;
        Read_Addr_1 = ra1;
        Read_Addr_2 = ra2;
        @(negedge clock);
    endtask

    task automatic idle_read(input logic [4:0] ra1, input logic [4:0] ra2);
        cyc(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, ra1, ra2);
    endtask

    initial begin
        logic [31:0] exp_same;
        logic        rst_r, rw_r, m2r_r;
        logic [4:0]  dest_r, ra1_r, ra2_r;

        cyc(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
        check_en = 1'b1;

        for (int i = 0; i < 32; i++) begin
            idle_read(i[4:0], 5'(31 - i));
            chk("reset_sweep_rd1", Read_Data_1, 32'h0);
            chk("reset_sweep_rd2", Read_Data_2, 32'h0);
        end

        cyc(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 32'h12345678, 5'd5, 5'd0, 5'd0);
        chk("mux_alu_wbdata", WB_Data_out, 32'h12345678);
        chk("mux_alu_valid", {31'd0, WB_Valid_out}, 32'd1);
        idle_read(5'd5, 5'd5);
        chk("mux_alu_rd1", Read_Data_1, 32'h12345678);
        cyc(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 32'h12345678, 5'd6, 5'd0, 5'd0);
        chk("mux_mem_wbdata", WB_Data_out, 32'hDEADBEEF);
        idle_read(5'd6, 5'd5);
        chk("mux_mem_rd1", Read_Data_1, 32'hDEADBEEF);
        chk("mux_mem_rd2_keep5", Read_Data_2, 32'h12345678);

        cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0);
        chk("r0_valid", {31'd0, WB_Valid_out}, 32'd0);
        chk("r0_same_rd1", Read_Data_1, 32'h0);
        chk("r0_same_rd2", Read_Data_2, 32'h0);
        idle_read(5'd0, 5'd0);
        chk("r0_next_rd1", Read_Data_1, 32'h0);

        cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h11111111, 5'd7, 5'd0, 5'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h22222222, 5'd7, 5'd7, 5'd7);
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'h22222222;
`else
        exp_same = 32'h11111111;
`endif
        chk("rw_same_rd1", Read_Data_1, exp_same);
        chk("rw_same_rd2", Read_Data_2, exp_same);
        idle_read(5'd7, 5'd7);
        chk("rw_next_rd1", Read_Data_1, 32'h22222222);
        chk("rw_next_rd2", Read_Data_2, 32'h22222222);

        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 1'b0, 32'hAAAAAAAA, 32'hAAAAAAAA, 5'd9, 5'd9, 5'd9);
        idle_read(5'd9, 5'd9);
        chk("gate_rd1", Read_Data_1, 32'h0);

        cyc(1'b0, 1'b1, 1'b0, 32'h0, 32'h55, 5'd3, 5'd0, 5'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0, 32'h77, 5'd3, 5'd3, 5'd3);
        chk("rst_cycle_rd1", Read_Data_1, 32'h55);
        idle_read(5'd3, 5'd5);
        chk("rst_after_rd1", Read_Data_1, 32'h0);
        chk("rst_after_rd2", Read_Data_2, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            rst_r  = ($urandom_range(0, 63) == 0);
            rw_r   = ($urandom_range(0, 3) != 0);
            m2r_r  = $urandom_range(0, 1) != 0;
            dest_r = (n < 1500) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ra1_r  = ($urandom_range(0, 3) == 0) ? dest_r : 5'($urandom_range(0, 31));
            ra2_r  = ($urandom_range(0, 3) == 0) ? dest_r : 5'($urandom_range(0, 31));
            cyc(rst_r, rw_r, m2r_r, $urandom, $urandom, dest_r, ra1_r, ra2_r);
        end

        @(posedge clock);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
